echo_ranging_sequencer: RTL and testbench
=========================================

Name: echo_ranging_sequencer

Overview:
- Sequences one ultrasonic ranging cycle: issues the trigger pulse, times the echo pulse in microsecond ticks, and reports the width or a timeout.
- Contains its own prescaler. A fixed divide of the system clock produces a 1-cycle microsecond tick enable; no derived clock is generated.
- Sits between the sensor pins and the distance-to-LED display logic.
- Supports single-shot operation on a request, and continuous operation at a fixed repetition period.

Parameters:
- TICK_DIV, 50, system clocks per microsecond tick (50 MHz → 1 µs); must be ≥2.
- TRIG_US, 10, trigger pulse width in ticks.
- TIMEOUT_US, 30000, maximum wait for echo rise, and maximum echo width, in ticks.
- PERIOD_US, 60000, minimum trigger-to-trigger spacing in ticks; must be > TRIG_US + 2*TIMEOUT_US is not required, only > TRIG_US.
- W, 16, width of EchoUs and internal tick counters; 2^W-1 ≥ PERIOD_US.

Ports:
- ClockIn  in  1  system clock.
- ResetN  in  1  asynchronous active-low reset.
- Start  in  1  single-shot request, sampled only in IDLE.
- Continuous  in  1  when high, IDLE auto-starts a new cycle.
- EchoIn  in  1  asynchronous sensor echo.
- TrigOut  out  1  sensor trigger, registered.
- Busy  out  1  high in every state except IDLE.
- DistValid  out  1  1-cycle pulse when EchoUs is updated.
- EchoUs  out  W  last measured echo width in ticks, held until the next DistValid.
- Timeout  out  1  1-cycle pulse when a cycle aborts on timeout.

Behaviour:
- Reset (async, ResetN=0): state IDLE; TrigOut=0, Busy=0, DistValid=0, Timeout=0, EchoUs=0; prescaler, tick counters and synchronizer are cleared.
- Echo synchronizer: 2-flop synchronizer on EchoIn, giving echo_s. Edge detection compares echo_s with its previous value. Input-to-edge latency is 3 clocks.
- Prescaler: counts 0..TICK_DIV-1 and wraps. tick=1 for one clock when count==TICK_DIV-1. The prescaler is forced to 0 on any transition into TRIG, so ticks are phase-aligned to the trigger.
- IDLE: if Start|Continuous is high at edge N, enter TRIG at edge N. TrigOut=1 and Busy=1 are visible after edge N. Clear tcnt (ticks in state) and pcnt (ticks since trigger).
- TRIG: TrigOut=1. tcnt increments on each tick. When tcnt reaches TRIG_US (exactly TRIG_US*TICK_DIV clocks high), go to WAIT_RISE, set TrigOut=0, clear tcnt.
- WAIT_RISE:
  - A rising edge of echo_s goes to MEASURE with tcnt=0.
  - Otherwise, when tcnt reaches TIMEOUT_US on a tick, pulse Timeout and go to HOLDOFF.
- MEASURE:
  - tcnt increments on each tick.
  - A falling edge of echo_s loads EchoUs=tcnt, pulses DistValid and goes to HOLDOFF.
  - Otherwise, when tcnt reaches TIMEOUT_US, pulse Timeout, leave EchoUs unchanged and go to HOLDOFF.
- HOLDOFF: wait until pcnt ≥ PERIOD_US, then go to IDLE. pcnt increments on each tick in every non-IDLE state and saturates at 2^W-1.
- Start while Busy is ignored and not queued. Continuous falling mid-cycle completes the current cycle, then the block stays in IDLE.
- Simultaneous falling edge and timeout in the same cycle: the falling edge wins, so DistValid pulses and Timeout does not.
- Echo already high when WAIT_RISE is entered does not count as a rising edge; the cycle times out.
- DistValid and Timeout are never high in the same cycle.
- ResetN asserted mid-cycle: TrigOut drops to 0 asynchronously and the cycle is abandoned with no pulse.

Optional Feature:
- Macro: ECHO_GLITCH_FILTER_EN.
- Defined: echo_s must be stable for 4 consecutive clocks before it updates a filtered echo level. Edges are detected on that filtered level, adding 3 clocks of latency. Pulses shorter than 4 clocks are rejected.
- Undefined: edges are detected directly on the 2-flop output, with no filter logic.

Test Plan:
- Reset: TICK_DIV=4. Hold ResetN=0 with Start=1 → all outputs 0. Release ResetN, pulse Start → TrigOut high for exactly 40 clocks (TRIG_US=10); Busy=1.
- Normal measurement: TICK_DIV=4. Drive EchoIn high for 580 ticks after the trigger → one DistValid pulse, EchoUs=580 ±1, Timeout stays 0; Busy stays high until PERIOD_US ticks after the trigger.
- No echo: TIMEOUT_US=100, EchoIn held low → Timeout pulses once, 100 ticks after TrigOut falls; EchoUs keeps its prior value; no DistValid.
- Stuck echo: EchoIn high through the whole of WAIT_RISE → no MEASURE, Timeout pulses; then EchoIn high for >TIMEOUT_US inside MEASURE → Timeout pulses, EchoUs unchanged.
- Continuous mode: Continuous=1, PERIOD_US=200 → TrigOut rising edges exactly 200*TICK_DIV+1 clocks apart (including the IDLE cycle). Extra Start pulses mid-cycle have no effect. Deassert Continuous → the block stops after the current cycle.
- Reset mid-cycle and filter: assert ResetN during TRIG → TrigOut=0 at once and no pulses after release. With ECHO_GLITCH_FILTER_EN, a 2-clock echo glitch in WAIT_RISE is ignored; without the macro, the same glitch yields DistValid with EchoUs=0.

Source files
------------

// File: rtl/echo_ranging_sequencer.sv
// -----------------------------------------------------------------------------
// echo_ranging_sequencer
//
// Runs one ultrasonic ranging cycle at a time:
//   1. raises the trigger for TRIG_US microsecond ticks,
//   2. waits up to TIMEOUT_US ticks for the echo to rise,
//   3. times the echo high width in ticks, up to TIMEOUT_US ticks,
//   4. holds off until PERIOD_US ticks have passed since the trigger.
// A built-in prescaler divides ClockIn by TICK_DIV to make a one-cycle tick
// enable. The prescaler is re-phased to the trigger, so all tick-based timing
// within a cycle is aligned to the trigger.
//
// Optional feature (compile-time macro ECHO_GLITCH_FILTER_EN):
//   defined   - the synchronized echo must hold a new level for 4 consecutive
//               clocks before it is accepted; shorter pulses are ignored.
//   undefined - edges are taken directly from the 2-flop synchronizer.
//
// Ports:
//   ClockIn     in   system clock
//   ResetN      in   asynchronous active-low reset
//   Start       in   single-shot request, only looked at while idle
//   Continuous  in   while high, an idle sequencer starts a new cycle
//   EchoIn      in   asynchronous sensor echo
//   TrigOut     out  registered sensor trigger
//   Busy        out  high whenever a ranging cycle is in progress
//   DistValid   out  one-cycle pulse when EchoUs is updated
//   EchoUs      out  last measured echo width in ticks (W bits)
//   Timeout     out  one-cycle pulse when a cycle is aborted on timeout
// -----------------------------------------------------------------------------
module echo_ranging_sequencer #(
  parameter int TICK_DIV   = 50,
  parameter int TRIG_US    = 10,
  parameter int TIMEOUT_US = 30000,
  parameter int PERIOD_US  = 60000,
  parameter int W          = 16
) (
  input  logic         ClockIn,
  input  logic         ResetN,
  input  logic         Start,
  input  logic         Continuous,
  input  logic         EchoIn,
  output logic         TrigOut,
  output logic         Busy,
  output logic         DistValid,
  output logic [W-1:0] EchoUs,
  output logic         Timeout
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST     = PW'(TICK_DIV - 1);
  localparam logic [W-1:0]  TRIG_LAST    = W'(TRIG_US - 1);
  localparam logic [W-1:0]  TIMEOUT_LAST = W'(TIMEOUT_US - 1);
  localparam logic [W-1:0]  PERIOD_TICKS = W'(PERIOD_US);
  localparam logic [W-1:0]  CNT_MAX      = '1;

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF} stateT;

  stateT          stateReg, stateNext;
  logic [PW-1:0]  preCntReg;
  logic           preClear;
  logic           tick;
  logic [W-1:0]   tcntReg, tcntNext, tcntStep;
  logic [W-1:0]   pcntReg, pcntNext, pcntStep;
  logic [W-1:0]   echoUsNext;
  logic           trigNext, busyNext, distValidNext, timeoutNext;
  logic           echoMeta, echoSync;
  logic           echoRise, echoFall;

  // ---------------------------------------------------------------- prescaler
  assign tick = (preCntReg == PRE_LAST);

  always_ff @(posedge ClockIn or negedge ResetN) begin
    if (!ResetN) begin
      preCntReg <= '0;
    end else if (preClear || tick) begin
      preCntReg <= '0;
    end else begin
      preCntReg <= preCntReg + 1'b1;
    end
  end

  // ------------------------------------------------------ echo synchronizer
  always_ff @(posedge ClockIn or negedge ResetN) begin
    if (!ResetN) begin
      echoMeta <= 1'b0;
      echoSync <= 1'b0;
    end else begin
      echoMeta <= EchoIn;
      echoSync <= echoMeta;
    end
  end

`ifdef ECHO_GLITCH_FILTER_EN
  // stableCnt counts consecutive clocks on which echoSync disagrees with the
  // accepted level; on the 4th such clock the new level is accepted and the
  // edge is reported in that same cycle.
  logic       echoFilt;
  logic [1:0] stableCnt;
  logic       filtUpdate;

  assign filtUpdate = (echoSync != echoFilt) && (stableCnt == 2'd3);
  assign echoRise   = filtUpdate &&  echoSync;
  assign echoFall   = filtUpdate && !echoSync;

  always_ff @(posedge ClockIn or negedge ResetN) begin
    if (!ResetN) begin
      echoFilt  <= 1'b0;
      stableCnt <= 2'd0;
    end else if (echoSync == echoFilt) begin
      stableCnt <= 2'd0;
    end else if (filtUpdate) begin
      echoFilt  <= echoSync;
      stableCnt <= 2'd0;
    end else begin
      stableCnt <= stableCnt + 2'd1;
    end
  end
`else
  logic echoPrev;

  assign echoRise = echoSync && !echoPrev;
  assign echoFall = !echoSync && echoPrev;

  always_ff @(posedge ClockIn or negedge ResetN) begin
    if (!ResetN) begin
      echoPrev <= 1'b0;
    end else begin
      echoPrev <= echoSync;
    end
  end
`endif

  // -------------------------------------------------------------- sequencer
  assign tcntStep = tick ? tcntReg + 1'b1 : tcntReg;
  assign pcntStep = (tick && pcntReg != CNT_MAX) ? pcntReg + 1'b1 : pcntReg;

  always_comb begin
    stateNext     = stateReg;
    tcntNext      = tcntReg;
    pcntNext      = pcntReg;
    echoUsNext    = EchoUs;
    distValidNext = 1'b0;
    timeoutNext   = 1'b0;
    preClear      = 1'b0;

    case (stateReg)
      IDLE: begin
        if (Start || Continuous) begin
          stateNext = TRIG;
          tcntNext  = '0;
          pcntNext  = '0;
          preClear  = 1'b1;
        end
      end
      TRIG: begin
        pcntNext = pcntStep;
        if (tick && tcntReg == TRIG_LAST) begin
          stateNext = WAIT_RISE;
          tcntNext  = '0;
        end else begin
          tcntNext = tcntStep;
        end
      end
      WAIT_RISE: begin
        pcntNext = pcntStep;
        // A rise wins over a timeout landing on the same clock.
        if (echoRise) begin
          stateNext = MEASURE;
          tcntNext  = '0;
        end else if (tick && tcntReg == TIMEOUT_LAST) begin
          stateNext   = HOLDOFF;
          timeoutNext = 1'b1;
        end else begin
          tcntNext = tcntStep;
        end
      end
      MEASURE: begin
        pcntNext = pcntStep;
        // A fall wins over a timeout landing on the same clock.
        if (echoFall) begin
          stateNext     = HOLDOFF;
          echoUsNext    = tcntReg;
          distValidNext = 1'b1;
        end else if (tick && tcntReg == TIMEOUT_LAST) begin
          stateNext   = HOLDOFF;
          timeoutNext = 1'b1;
        end else begin
          tcntNext = tcntStep;
        end
      end
      HOLDOFF: begin
        pcntNext = pcntStep;
        // Looking at the stepped count lets IDLE be entered on the very edge
        // the period elapses, so back-to-back cycles are PERIOD_US ticks plus
        // one idle clock apart.
        if (pcntStep >= PERIOD_TICKS) begin
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase

    trigNext = (stateNext == TRIG);
    busyNext = (stateNext != IDLE);
  end

  always_ff @(posedge ClockIn or negedge ResetN) begin
    if (!ResetN) begin
      stateReg  <= IDLE;
      tcntReg   <= '0;
      pcntReg   <= '0;
      TrigOut   <= 1'b0;
      Busy      <= 1'b0;
      DistValid <= 1'b0;
      Timeout   <= 1'b0;
      EchoUs    <= '0;
    end else begin
      stateReg  <= stateNext;
      tcntReg   <= tcntNext;
      pcntReg   <= pcntNext;
      TrigOut   <= trigNext;
      Busy      <= busyNext;
      DistValid <= distValidNext;
      Timeout   <= timeoutNext;
      EchoUs    <= echoUsNext;
    end
  end

endmodule

// File: tb/tb_echo_ranging_sequencer.sv
// -----------------------------------------------------------------------------
// tb_echo_ranging_sequencer
//
// Self-checking bench for echo_ranging_sequencer (TICK_DIV=4, TRIG_US=10,
// TIMEOUT_US=100, PERIOD_US=300). Each ranging cycle is described by the
// trigger edge T and the echo pulse (rise/fall clock offsets from T). A
// transaction-level model turns that into the edges at which TrigOut, Busy,
// DistValid and Timeout change and the EchoUs value, and one process compares
// the DUT against it every clock. Directed literal checks pin the model.
// Honours ECHO_GLITCH_FILTER_EN like the design.
// -----------------------------------------------------------------------------
module tb_echo_ranging_sequencer;

  localparam int D     = 4;
  localparam int TRIGU = 10;
  localparam int TO    = 100;
  localparam int P     = 300;
  localparam int W     = 16;
`ifdef ECHO_GLITCH_FILTER_EN
  localparam int L    = 6;   // EchoIn change to state change, in clocks
  localparam int MINW = 4;   // shortest echo pulse that is accepted
`else
  localparam int L    = 3;
  localparam int MINW = 1;
`endif
  localparam int NONE = 1 << 30;

  logic         ClockIn    = 1'b0;
  logic         ResetN     = 1'b0;
  logic         Start      = 1'b0;
  logic         Continuous = 1'b0;
  logic         EchoIn     = 1'b0;
  logic         TrigOut, Busy, DistValid, Timeout;
  logic [W-1:0] EchoUs;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  bit inReset = 1'b1;

  // model of the current transaction (edge indices)
  int mT = NONE, mTw = NONE, mX = 0, mDv = -1, mTo = -1;
  int mEchoNew = 0, mEchoOld = 0;

  // monitors on DUT outputs for the literal checks
  logic prevTrig = 1'b0;
  int riseCount = 0, riseEdge = 0, prevRiseEdge = 0;
  int trigRun = 0, lastTrigWidth = 0, trigFallEdge = 0, timeoutEdge = 0;
  int dvCount = 0, toCount = 0;

  echo_ranging_sequencer #(
    .TICK_DIV(D), .TRIG_US(TRIGU), .TIMEOUT_US(TO), .PERIOD_US(P), .W(W)
  ) dut (
    .ClockIn(ClockIn), .ResetN(ResetN), .Start(Start), .Continuous(Continuous),
    .EchoIn(EchoIn), .TrigOut(TrigOut), .Busy(Busy), .DistValid(DistValid),
    .EchoUs(EchoUs), .Timeout(Timeout)
  );

  always #5 ClockIn = ~ClockIn;

  initial forever begin
    @(posedge ClockIn);
    cyc++;
  end

  // Predict one ranging cycle triggered at edge T with EchoIn high after
  // edges T+r .. T+f-1 (r<0: no echo). Ticks land on edges T+D*k, k>=1.
  task automatic plan(input int T, input int r, input int f);
    int tw, er, k0, em, ef, h;
    if (mDv >= 0) mEchoOld = mEchoNew;
    mDv = -1;
    mTo = -1;
    tw  = T + TRIGU * D;
    er  = -1;
    if (r >= 0 && (f - r) >= MINW) er = T + r + L;
    if (er > tw && er <= tw + TO * D) begin
      k0 = (er - T) / D;
      em = T + D * (k0 + TO);
      ef = T + f + L;
      if (ef <= em) begin
        mDv      = ef;
        mEchoNew = (ef - 1 - T) / D - k0;
        h        = ef;
      end else begin
        mTo = em;
        h   = em;
      end
    end else begin
      mTo = tw + TO * D;
      h   = mTo;
    end
    mT  = T;
    mTw = tw;
    mX  = (h + 1 > T + P * D) ? h + 1 : T + P * D;
  endtask

  task automatic model_reset();
    mT = NONE; mTw = NONE; mX = 0; mDv = -1; mTo = -1;
    mEchoNew = 0; mEchoOld = 0;
  endtask

  task automatic check(input string name, input int got, input int lo, input int hi);
    vectors++;
    if (got < lo || got > hi) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, got, lo, hi);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge ClockIn);
    #1;
  endtask

  // Called just after an edge; the cycle triggers on the next edge.
  task automatic run_cycle(input int r, input int f, input bit useStart, input bit contAfter);
    int T;
    T = cyc + 1;
    plan(T, r, f);
    Start  = useStart;
    EchoIn = 1'b0;
    while (cyc < mX) begin
      @(posedge ClockIn);
      #1;
      EchoIn = (r >= 0 && cyc >= T + r && cyc < T + f);
      Start  = (cyc >= T && cyc < mX - 1 && $urandom_range(0, 40) == 0);
      if (cyc == T + 100) Continuous = contAfter;
    end
    Start  = 1'b0;
    EchoIn = 1'b0;
  endtask

  // per-clock compare against the model, plus output monitors
  initial forever begin
    bit expTrig, expBusy, expDv, expTo;
    int expEcho;
    @(negedge ClockIn);
    if (!inReset) begin
      expTrig = (cyc >= mT && cyc < mTw);
      expBusy = (cyc >= mT && cyc < mX);
      expDv   = (cyc == mDv);
      expTo   = (cyc == mTo);
      expEcho = (mDv >= 0 && cyc >= mDv) ? mEchoNew : mEchoOld;
      vectors++;
      if (TrigOut !== expTrig || Busy !== expBusy || DistValid !== expDv ||
          Timeout !== expTo || EchoUs !== W'(expEcho)) begin
        miscompares++;
        $display("FAIL cycle_check @edge %0d: got trig=%b busy=%b dv=%b to=%b echo=%0d, expected trig=%b busy=%b dv=%b to=%b echo=%0d",
                 cyc, TrigOut, Busy, DistValid, Timeout, EchoUs,
                 expTrig, expBusy, expDv, expTo, expEcho);
      end
    end
    if (TrigOut === 1'b1 && prevTrig === 1'b0) begin
      riseCount++;
      prevRiseEdge = riseEdge;
      riseEdge = cyc;
      trigRun = 0;
    end
    if (TrigOut === 1'b1) trigRun++;
    if (TrigOut === 1'b0 && prevTrig === 1'b1) begin
      lastTrigWidth = trigRun;
      trigFallEdge = cyc;
    end
    if (Timeout === 1'b1) begin
      toCount++;
      timeoutEdge = cyc;
    end
    if (DistValid === 1'b1) dvCount++;
    prevTrig = TrigOut;
  end

  initial begin
    #5_000_000;
    miscompares++;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    int rc, dv0, to0, r, w, f;
    bit contOn, contAfter;

    // reset held with Start high: everything stays at 0
    ResetN = 1'b0;
    Start  = 1'b1;
    repeat (3) begin
      @(negedge ClockIn);
      #1;
      check("reset_flags", int'({TrigOut, Busy, DistValid, Timeout}), 0, 0);
      check("reset_echo", int'(EchoUs), 0, 0);
    end
    @(posedge ClockIn);
    #1;
    ResetN  = 1'b1;
    Start   = 1'b0;
    inReset = 1'b0;
    wait_cycles(3);

    // normal measurement: 58-tick echo
    run_cycle(50, 50 + 58 * D, 1'b1, 1'b0);
    check("trig_width_clocks", lastTrigWidth, 40, 40);
    check("normal_echo_us", int'(EchoUs), 57, 59);
    check("normal_dv_count", dvCount, 1, 1);
    check("normal_to_count", toCount, 0, 0);
    wait_cycles(2);

    // no echo: timeout 100 ticks after the trigger falls
    run_cycle(-1, 0, 1'b1, 1'b0);
    check("noecho_timeout_delay", timeoutEdge - trigFallEdge, TO * D, TO * D);
    check("noecho_to_count", toCount, 1, 1);
    check("noecho_dv_count", dvCount, 1, 1);
    check("noecho_echo_held", int'(EchoUs), 57, 59);
    wait_cycles(1);

    // echo already high through WAIT_RISE
    run_cycle(5, 40 + TO * D + 60, 1'b1, 1'b0);
    check("stuckwait_to_count", toCount, 2, 2);
    check("stuckwait_dv_count", dvCount, 1, 1);
    wait_cycles(1);

    // echo longer than the timeout inside MEASURE
    run_cycle(60, 60 + TO * D + 40, 1'b1, 1'b0);
    check("stuckmeas_to_count", toCount, 3, 3);
    check("stuckmeas_echo_held", int'(EchoUs), 57, 59);
    wait_cycles(1);

    // 2-clock glitch in WAIT_RISE
    run_cycle(58, 60, 1'b1, 1'b0);
`ifdef ECHO_GLITCH_FILTER_EN
    check("glitch_dv_count", dvCount, 1, 1);
    check("glitch_to_count", toCount, 4, 4);
`else
    check("glitch_dv_count", dvCount, 2, 2);
    check("glitch_echo_us", int'(EchoUs), 0, 0);
`endif
    wait_cycles(1);

    // continuous mode, then drop Continuous in the third cycle
    run_cycle(100, 300, 1'b1, 1'b1);
    run_cycle(200, 260, 1'b0, 1'b1);
    check("cont_spacing_1", riseEdge - prevRiseEdge, P * D + 1, P * D + 1);
    run_cycle(-1, 0, 1'b0, 1'b0);
    check("cont_spacing_2", riseEdge - prevRiseEdge, P * D + 1, P * D + 1);
    rc = riseCount;
    wait_cycles(300);
    check("cont_stopped", riseCount, rc, rc);

    // reset during TRIG
    Start = 1'b1;
    plan(cyc + 1, -1, 0);
    wait_cycles(1);
    Start = 1'b0;
    wait_cycles(15);
    @(negedge ClockIn);
    #2;
    inReset = 1'b1;
    ResetN  = 1'b0;
    #1;
    check("midreset_trig", int'(TrigOut), 0, 0);
    check("midreset_busy", int'(Busy), 0, 0);
    check("midreset_echo", int'(EchoUs), 0, 0);
    dv0 = dvCount;
    to0 = toCount;
    rc  = riseCount;
    @(posedge ClockIn);
    @(posedge ClockIn);
    #1;
    ResetN = 1'b1;
    model_reset();
    inReset = 1'b0;
    wait_cycles(600);
    check("midreset_no_dv", dvCount, dv0, dv0);
    check("midreset_no_to", toCount, to0, to0);
    check("midreset_no_trig", riseCount, rc, rc);

    // randomized cycles
    contOn = 1'b0;
    for (int i = 0; i < 16; i++) begin
      r = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 700));
      w = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 6)) : int'($urandom_range(8, 600));
      f = r + w;
      if (f > P * D - 20) f = P * D - 20;
      contAfter = (i < 15) && ($urandom_range(0, 2) == 0);
      if (!contOn) wait_cycles($urandom_range(1, 5));
      run_cycle(r, f, !contOn, contAfter);
      contOn = contAfter;
    end
    wait_cycles(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
